// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS ISA definitions for the instruction encoder and
// the opcode/function control decoder.
//   op_e      : symbolic operation enum (values 0..29; 30 and 31 are illegal)
//   OPC_*/FN_*: primary opcode and R-type funct field values
//   RT_*      : REGIMM rt selectors (BGEZ/BLTZ share one opcode)
//   op_legal  : true for enum values the encoder knows
//   encode    : assembles the 32-bit instruction word from request fields
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLT, OP_SLL, OP_SRL,
    OP_JR, OP_MUL, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW, OP_SW,
    OP_LB, OP_SB, OP_LH, OP_SH, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BGEZ,
    OP_BLTZ, OP_J, OP_JAL
  } op_e;

  localparam logic [4:0] OP_LAST = 5'd29;

  localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OPC_REGIMM   = 6'b000001;
  localparam logic [5:0] OPC_ADDI     = 6'b001000;
  localparam logic [5:0] OPC_ANDI     = 6'b001100;
  localparam logic [5:0] OPC_ORI      = 6'b001101;
  localparam logic [5:0] OPC_XORI     = 6'b001110;
  localparam logic [5:0] OPC_SLTI     = 6'b001010;
  localparam logic [5:0] OPC_LW       = 6'b100011;
  localparam logic [5:0] OPC_SW       = 6'b101011;
  localparam logic [5:0] OPC_LB       = 6'b100000;
  localparam logic [5:0] OPC_SB       = 6'b101000;
  localparam logic [5:0] OPC_LH       = 6'b100001;
  localparam logic [5:0] OPC_SH       = 6'b101001;
  localparam logic [5:0] OPC_BEQ      = 6'b000100;
  localparam logic [5:0] OPC_BNE      = 6'b000101;
  localparam logic [5:0] OPC_BGTZ     = 6'b000111;
  localparam logic [5:0] OPC_BLEZ     = 6'b000110;
  localparam logic [5:0] OPC_J        = 6'b000010;
  localparam logic [5:0] OPC_JAL      = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b000010;

  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] RT_BLTZ = 5'b00000;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_LAST;
  endfunction

  function automatic logic [31:0] encode(input logic [4:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  shamt,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADD:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_OR};
      OP_NOR:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_NOR};
      OP_XOR:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_XOR};
      OP_SLT:  w = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLT};
      // Shifts take their amount from shamt; rs is unused and forced to 0.
      OP_SLL:  w = {OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SLL};
      OP_SRL:  w = {OPC_SPECIAL, 5'd0, rt, rd, shamt, FN_SRL};
      OP_JR:   w = {OPC_SPECIAL, rs, 15'd0, FN_JR};
      OP_MUL:  w = {OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_MUL};
      OP_ADDI: w = {OPC_ADDI, rs, rt, imm};
      OP_ANDI: w = {OPC_ANDI, rs, rt, imm};
      OP_ORI:  w = {OPC_ORI,  rs, rt, imm};
      OP_XORI: w = {OPC_XORI, rs, rt, imm};
      OP_SLTI: w = {OPC_SLTI, rs, rt, imm};
      OP_LW:   w = {OPC_LW,   rs, rt, imm};
      OP_SW:   w = {OPC_SW,   rs, rt, imm};
      OP_LB:   w = {OPC_LB,   rs, rt, imm};
      OP_SB:   w = {OPC_SB,   rs, rt, imm};
      OP_LH:   w = {OPC_LH,   rs, rt, imm};
      OP_SH:   w = {OPC_SH,   rs, rt, imm};
      OP_BEQ:  w = {OPC_BEQ,  rs, rt, imm};
      OP_BNE:  w = {OPC_BNE,  rs, rt, imm};
      OP_BGTZ: w = {OPC_BGTZ, rs, 5'd0, imm};
      OP_BLEZ: w = {OPC_BLEZ, rs, 5'd0, imm};
      // BGEZ/BLTZ share REGIMM; the rt field selects the comparison.
      OP_BGEZ: w = {OPC_REGIMM, rs, RT_BGEZ, imm};
      OP_BLTZ: w = {OPC_REGIMM, rs, RT_BLTZ, imm};
      OP_J:    w = {OPC_J,   target};
      OP_JAL:  w = {OPC_JAL, target};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: synchronous FIFO buffering encoded words ahead of the
// instruction-memory write port.
//   clk, rst_n : clock, asynchronous active-low reset of pointers/count
//   flush      : synchronous clear, wins over push/pop in the same cycle
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (valid while !empty)
//   empty      : no entries held
//   count      : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_enc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is plain data: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic instruction requests into 32-bit MIPS words
// and writes them to instruction memory at auto-incrementing word addresses.
//   Clk, Rst_n        : clock, asynchronous active-low reset
//   ReqValid/ReqReady : request handshake; ReqOp plus ReqRs/Rt/Rd/Shamt/Imm/Target
//   Flush             : synchronous restart (drops buffered words, rewinds address)
//   MemWrEn/MemAddr/MemWrData/MemReady : instruction-memory write port
//   Count             : instructions written, saturating at all-ones
//   Error             : sticky flag, set when an illegal op (30/31) is accepted
// Optional: define INSTR_ENC_PARITY_EN to add MemWrParity, the even parity of
// MemWrData, carried through the FIFO beside each word.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [4:0]        ReqOp,
  input  logic [4:0]        ReqRs,
  input  logic [4:0]        ReqRt,
  input  logic [4:0]        ReqRd,
  input  logic [4:0]        ReqShamt,
  input  logic [15:0]       ReqImm,
  input  logic [25:0]       ReqTarget,
  input  logic              Flush,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  input  logic              MemReady,
  output logic [ADDR_W:0]   Count,
`ifdef INSTR_ENC_PARITY_EN
  output logic              Error,
  output logic              MemWrParity
`else
  output logic              Error
`endif
);

`ifdef INSTR_ENC_PARITY_EN
  localparam int FIFO_W = 33;
`else
  localparam int FIFO_W = 32;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              run_q;
  logic              accept;
  logic              pop;
  logic [31:0]       word_p1;
  logic              vld_p1;
  logic [FIFO_W-1:0] push_data;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;

  // Keeps ReqReady low while in reset and for the first edge after release.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Counting the word in the encode stage guarantees the FIFO never overflows.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(vld_p1);
  assign ReqReady  = run_q && !Flush && (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = ReqValid && ReqReady;
  assign pop       = !fifo_empty && MemReady && !Flush;

  // ---- stage p1: encode register (accept edge) ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_p1 <= 1'b0;
      Error  <= 1'b0;
    end else if (Flush) begin
      vld_p1 <= 1'b0;
      Error  <= 1'b0;
    end else begin
      vld_p1 <= accept && op_legal(ReqOp);
      if (accept && !op_legal(ReqOp)) Error <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) word_p1 <= encode(ReqOp, ReqRs, ReqRt, ReqRd, ReqShamt, ReqImm, ReqTarget);
  end

  // ---- stage p2: FIFO push, head drives the write port ----
`ifdef INSTR_ENC_PARITY_EN
  assign push_data   = {^word_p1, word_p1};
  assign MemWrParity = fifo_empty ? 1'b0 : fifo_head[32];
`else
  assign push_data   = word_p1;
`endif

  instr_enc_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .flush     (Flush),
    .push      (vld_p1),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Data is forced to zero when idle so stale storage never shows on the port.
  assign MemWrEn   = !fifo_empty;
  assign MemWrData = fifo_empty ? 32'd0 : fifo_head[31:0];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MemAddr <= BASE;
      Count   <= '0;
    end else if (Flush) begin
      MemAddr <= BASE;
      Count   <= '0;
    end else if (pop) begin
      MemAddr <= MemAddr + ADDR_W'(1);
      if (Count != '1) Count <= Count + (ADDR_W + 1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic [4:0]  ReqOp = '0;
  logic [4:0]  ReqRs = '0;
  logic [4:0]  ReqRt = '0;
  logic [4:0]  ReqRd = '0;
  logic [4:0]  ReqShamt = '0;
  logic [15:0] ReqImm = '0;
  logic [25:0] ReqTarget = '0;
  logic        Flush = 1'b0;
  logic        MemReady = 1'b1;

  logic        ReqReady, MemWrEn, Error;
  logic [9:0]  MemAddr;
  logic [31:0] MemWrData;
  logic [10:0] Count;
  logic        ReqReady2, MemWrEn2, Error2;
  logic [1:0]  MemAddr2;
  logic [31:0] MemWrData2;
  logic [2:0]  Count2;
`ifdef INSTR_ENC_PARITY_EN
  logic        MemWrParity, MemWrParity2;
`endif

  always #5 Clk = ~Clk;

  instr_encoder #(.ADDR_W(10), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqRs(ReqRs), .ReqRt(ReqRt), .ReqRd(ReqRd),
    .ReqShamt(ReqShamt), .ReqImm(ReqImm), .ReqTarget(ReqTarget),
    .Flush(Flush), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemReady(MemReady), .Count(Count),
`ifdef INSTR_ENC_PARITY_EN
    .Error(Error), .MemWrParity(MemWrParity)
`else
    .Error(Error)
`endif
  );

  // Narrow-address instance driven in lockstep to exercise wrap and saturation.
  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady2),
    .ReqOp(ReqOp), .ReqRs(ReqRs), .ReqRt(ReqRt), .ReqRd(ReqRd),
    .ReqShamt(ReqShamt), .ReqImm(ReqImm), .ReqTarget(ReqTarget),
    .Flush(Flush), .MemWrEn(MemWrEn2), .MemAddr(MemAddr2), .MemWrData(MemWrData2),
    .MemReady(MemReady), .Count(Count2),
`ifdef INSTR_ENC_PARITY_EN
    .Error(Error2), .MemWrParity(MemWrParity2)
`else
    .Error(Error2)
`endif
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Holds ReqValid until accepted or budget cycles pass; returns at posedge+1.
  task automatic send(input logic [4:0] op, input logic [31:0] word, input int budget,
                      output bit ok);
    ReqOp = op;
    ReqValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (ReqReady) begin
        @(posedge Clk);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      ReqValid = 1'b0;
      @(posedge Clk);
    end
    #1;
    ReqValid = 1'b0;
    if (ok && op <= 5'd29) begin
      sb.push_back('{addr: exp_addr, data: word});
      exp_addr++;
    end
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    sb.delete();
    exp_addr = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge Clk);
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every handshake on the write port must match the oldest entry.
  always @(negedge Clk) begin
    if (Rst_n && !Flush && MemWrEn && MemReady) begin
      chk("write_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(MemAddr), 64'(e.addr));
        chk("wr_data", 64'(MemWrData), 64'(e.data));
        chk("wr_en2", 64'(MemWrEn2), 64'd1);
        chk("wr_addr2", 64'(MemAddr2), 64'(e.addr[1:0]));
        chk("wr_data2", 64'(MemWrData2), 64'(e.data));
`ifdef INSTR_ENC_PARITY_EN
        chk("wr_parity", 64'(MemWrParity), 64'(^e.data));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0]  tops   [30];
  logic [31:0] twords [30];
  bit          ok;
  int          acc;

  initial begin
    tops   = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
               5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19,
               5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29};
    twords = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825, 32'h00221827,
               32'h00221826, 32'h0022182A, 32'h00021900, 32'h00021902, 32'h00200008,
               32'h70221802, 32'h20221234, 32'h30221234, 32'h34221234, 32'h38221234,
               32'h28221234, 32'h8C221234, 32'hAC221234, 32'h80221234, 32'hA0221234,
               32'h84221234, 32'hA4221234, 32'h10221234, 32'h14221234, 32'h1C201234,
               32'h18201234, 32'h04211234, 32'h04201234, 32'h08ABCDEF, 32'h0CABCDEF};

    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ready", 64'(ReqReady), 64'd0);
    chk("rst_wren", 64'(MemWrEn), 64'd0);
    chk("rst_addr", 64'(MemAddr), 64'd0);
    chk("rst_data", 64'(MemWrData), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_error", 64'(Error), 64'd0);
    Rst_n = 1'b1;

    // ADD rs=1 rt=2 rd=3: latency and first write
    ReqRs = 5'd1; ReqRt = 5'd2; ReqRd = 5'd3; ReqShamt = 5'd0;
    send(5'd0, 32'h00221820, 20, ok);
    chk("add_accept", 64'(ok), 64'd1);
    chk("add_wren_n", 64'(MemWrEn), 64'd0);
    @(posedge Clk); #1;
    chk("add_wren_n1", 64'(MemWrEn), 64'd1);
    chk("add_addr", 64'(MemAddr), 64'd0);
    chk("add_data", 64'(MemWrData), 64'h00221820);
    @(posedge Clk); #1;
    chk("add_count", 64'(Count), 64'd1);
    chk("add_idle", 64'(MemWrEn), 64'd0);

    // BGEZ / BLTZ share an opcode
    do_flush();
    ReqRs = 5'd4; ReqRt = 5'd0; ReqImm = 16'h0010;
    send(5'd26, 32'h04810010, 20, ok);
    chk("bgez_accept", 64'(ok), 64'd1);
    send(5'd27, 32'h04800010, 20, ok);
    chk("bltz_accept", 64'(ok), 64'd1);
    drain("regimm_drain");

    // Back-pressure: 6 requests with MemReady low, 4 fit
    do_flush();
    MemReady = 1'b0;
    ReqRs = 5'd1; ReqRt = 5'd2;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      ReqImm = 16'(i + 1);
      send(5'd11, 32'h20220000 | 32'(i + 1), 3, ok);
      if (ok) acc++;
    end
    chk("stall_accepted", 64'(acc), 64'd4);
    chk("stall_ready", 64'(ReqReady), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("stall_wren", 64'(MemWrEn), 64'd1);
      chk("stall_addr", 64'(MemAddr), 64'd0);
      chk("stall_data", 64'(MemWrData), 64'h20220001);
    end
    MemReady = 1'b1;
    drain("stall_drain");
    chk("stall_count", 64'(Count), 64'd4);

    // Illegal op then ORI
    do_flush();
    ReqRs = 5'd0; ReqRt = 5'd5; ReqImm = 16'h00FF;
    send(5'd31, 32'd0, 20, ok);
    chk("ill_accept", 64'(ok), 64'd1);
    repeat (2) @(posedge Clk);
    #1;
    chk("ill_wren", 64'(MemWrEn), 64'd0);
    chk("ill_addr", 64'(MemAddr), 64'd0);
    chk("ill_count", 64'(Count), 64'd0);
    chk("ill_error", 64'(Error), 64'd1);
    send(5'd13, 32'h340500FF, 20, ok);
    chk("ori_accept", 64'(ok), 64'd1);
    drain("ori_drain");
    chk("ori_count", 64'(Count), 64'd1);
    chk("ori_error", 64'(Error), 64'd1);

    // Flush with 3 FIFO entries; request during flush refused
    MemReady = 1'b0;
    ReqRs = 5'd1; ReqRt = 5'd2; ReqImm = 16'h1234;
    for (int i = 0; i < 3; i++) send(5'd11, 32'h20221234, 20, ok);
    repeat (2) @(posedge Clk);
    #1;
    chk("fl_pre_wren", 64'(MemWrEn), 64'd1);
    chk("fl_pre_ready", 64'(ReqReady), 64'd1);
    Flush = 1'b1;
    ReqValid = 1'b1;
    @(negedge Clk);
    chk("fl_ready", 64'(ReqReady), 64'd0);
    @(posedge Clk); #1;
    Flush = 1'b0;
    ReqValid = 1'b0;
    sb.delete();
    exp_addr = '0;
    chk("fl_wren", 64'(MemWrEn), 64'd0);
    chk("fl_addr", 64'(MemAddr), 64'd0);
    chk("fl_count", 64'(Count), 64'd0);
    chk("fl_error", 64'(Error), 64'd0);
    MemReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("fl_quiet", 64'(MemWrEn), 64'd0);

    // Full op table
    ReqRs = 5'd1; ReqRt = 5'd2; ReqRd = 5'd3; ReqShamt = 5'd4;
    ReqImm = 16'h1234; ReqTarget = 26'h0ABCDEF;
    for (int i = 0; i < 30; i++) begin
      send(tops[i], twords[i], 20, ok);
      chk("tbl_accept", 64'(ok), 64'd1);
    end
    drain("tbl_drain");
    chk("tbl_count", 64'(Count), 64'd30);
    chk("tbl_count2_sat", 64'(Count2), 64'd7);
    chk("tbl_addr", 64'(MemAddr), 64'd30);

    // Async reset mid-write
    MemReady = 1'b0;
    send(5'd0, 32'h00221820, 20, ok);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst2_pre_wren", 64'(MemWrEn), 64'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rst2_ready", 64'(ReqReady), 64'd0);
    chk("rst2_wren", 64'(MemWrEn), 64'd0);
    chk("rst2_addr", 64'(MemAddr), 64'd0);
    chk("rst2_data", 64'(MemWrData), 64'd0);
    chk("rst2_count", 64'(Count), 64'd0);
    chk("rst2_error", 64'(Error), 64'd0);
    chk("rst2_wren2", 64'(MemWrEn2), 64'd0);
    sb.delete();
    exp_addr = '0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    MemReady = 1'b1;

    // J target=0x40: narrow instance wraps its address
    ReqTarget = 26'h0000040;
    for (int i = 0; i < 5; i++) begin
      send(5'd28, 32'h08000040, 20, ok);
      chk("j_accept", 64'(ok), 64'd1);
    end
    drain("j_drain");
    chk("j_count", 64'(Count), 64'd5);
    chk("j_count2", 64'(Count2), 64'd5);
    chk("j_addr", 64'(MemAddr), 64'd5);
    chk("j_addr2", 64'(MemAddr2), 64'd1);
    for (int i = 0; i < 3; i++) send(5'd28, 32'h08000040, 20, ok);
    drain("j_sat_drain");
    chk("j_count2_sat", 64'(Count2), 64'd7);
    chk("j_count8", 64'(Count), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the opcode/function control decoder.
- Accepts symbolic instruction requests (operation enum plus register, immediate and target fields) over a valid/ready handshake.
- Assembles the 32-bit MIPS word and streams it through an internal FIFO into the instruction-memory write port at auto-incrementing word addresses.
- Used by the testbench/program loader to build programs for the datapath without hand-coded hex.

Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- FIFO_DEPTH, 4: output buffer entries (power of two, >=2).
- BASE_ADDR, 0: word address of the first write after reset or Flush.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  request accepted when ReqValid&ReqReady at rising Clk.
- ReqOp  in  5  operation enum (package).
- ReqRs  in  5  rs field.
- ReqRt  in  5  rt field.
- ReqRd  in  5  rd field.
- ReqShamt  in  5  shift amount.
- ReqImm  in  16  immediate / branch offset.
- ReqTarget  in  26  jump target.
- Flush  in  1  synchronous restart.
- MemWrEn  out  1  write request (FIFO non-empty).
- MemAddr  out  ADDR_W  word address of the current write.
- MemWrData  out  32  encoded instruction.
- MemReady  in  1  memory accepts the write when MemWrEn&MemReady.
- Count  out  ADDR_W+1  instructions written, saturating.
- Error  out  1  sticky illegal-op flag.

Behaviour:
- Reset (Rst_n low, async): ReqReady=0, MemWrEn=0, MemAddr=BASE_ADDR, MemWrData=0, Count=0, Error=0; FIFO and encode stage emptied. This applies mid-operation; all in-flight words are lost.
- Pipeline:
  - Accept edge N: encoded word is registered in the encode stage.
  - Edge N+1: word is pushed to the FIFO.
  - MemWrEn is high after edge N+1, so latency is 2 clocks with MemReady=1.
- ReqReady = !Flush && (fifo_count + stage_valid) < FIFO_DEPTH. Never overflows. Stage push and FIFO pop in the same cycle are legal.
- Write port:
  - MemWrData/MemAddr are held stable while MemWrEn&!MemReady.
  - On handshake, the FIFO pops, MemAddr increments modulo 2^ADDR_W (wraps to 0), and Count increments, saturating at all-ones.
- Enum 0..29: ADD SUB AND OR NOR XOR SLT SLL SRL JR MUL ADDI ANDI ORI XORI SLTI LW SW LB SB LH SH BEQ BNE BGTZ BLEZ BGEZ BLTZ J JAL.
- R-type: opcode 0.
  - funct: ADD 100000, SUB 100010, AND 100100, OR 100101, NOR 100111, XOR 100110, SLT 101010, SLL 000000, SRL 000010, JR 001000.
  - SLL/SRL force rs=0. JR forces rt=rd=shamt=0. Other R-types force shamt=0.
- MUL: opcode 011100, funct 000010.
- I-type opcodes: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LW 100011, SW 101011, LB 100000, SB 101000, LH 100001, SH 101001, BEQ 000100, BNE 000101, BGTZ 000111 (rt=0), BLEZ 000110 (rt=0).
- BGEZ: opcode 000001, rt=00001. BLTZ: opcode 000001, rt=00000. The rt field disambiguates the shared opcode.
- J: 000010 with target. JAL: 000011 with target.
- Illegal enum (30, 31): still accepted; nothing is written; Error set sticky; MemAddr/Count unchanged.
- Flush (highest priority after reset):
  - Same edge: FIFO and stage cleared, MemAddr=BASE_ADDR, Count=0, Error=0.
  - Request in that cycle is not accepted (ReqReady=0).
  - A concurrent memory handshake is discarded.

Optional Feature:
- INSTR_ENC_PARITY_EN defined: adds output MemWrParity (1 bit) = even parity (XOR-reduce) of MemWrData, stored in the FIFO alongside the word and reset to 0.
- Undefined: port and FIFO bit are absent.

Decomposition:
- mips_isa_pkg holds the op enum, the opcode/funct/REGIMM-rt constants, and an encode function; the controller is to share it.
- One sub-module, instr_enc_fifo: synchronous FIFO with parameterized width/depth and a flush input.

Test Plan:
- Reset release, ADD rs=1 rt=2 rd=3, MemReady=1 -> MemWrData=0x00221820 at addr 0, MemWrEn 2 clocks after accept, Count=1.
- BGEZ rs=4 imm=0x0010, then BLTZ same fields -> 0x04810010 at addr 0, 0x04800010 at addr 1.
- MemReady=0, 6 back-to-back requests, FIFO_DEPTH=4 -> exactly 4 accepted, ReqReady low. MemReady=1 -> writes in order at addrs 0..3, data stable while stalled.
- Op=31 then ORI rs=0 rt=5 imm=0x00FF -> no write for op 31, Error=1; 0x340500FF written at addr 0.
- Flush with 3 FIFO entries -> MemWrEn=0 next cycle, MemAddr=BASE_ADDR, Count=0, Error=0. Rst_n pulsed low mid-write -> all outputs at reset values immediately.
- ADDR_W=2, 5 J target=0x0000040 writes -> addrs 0,1,2,3,0; data 0x08000040; Count=5.
